// File: rtl/serial_word_framer_pkg.sv
// Shared types and constants for the serial word framer.
// Build option: HDR_CNT_EN adds the saturating header counter port.
package framer_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] HDR_A_DEF = 8'hA5;
   localparam logic [BYTE_W-1:0] HDR_B_DEF = 8'hC3;

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } framer_state_t;

   function automatic logic is_header(
      input logic [BYTE_W-1:0] value,
      input logic [BYTE_W-1:0] hdr_a,
      input logic [BYTE_W-1:0] hdr_b
   );
      return (value == hdr_a) || (value == hdr_b);
   endfunction

endpackage

// File: rtl/serial_word_framer_shift8.sv
// 8-bit MSB-first serial shift register with enable and synchronous clear.
// next_sr is the combinational view of the window including the current bit.
module serial_shift8
   import framer_pkg::*;
(
   input  logic              clk_50,
   input  logic              reset,
   input  logic              ena,
   input  logic              clr,
   input  logic              din,
   output logic [BYTE_W-1:0] next_sr
);

   logic [BYTE_W-1:0] sr_reg;

   assign next_sr = {sr_reg[BYTE_W-2:0], din};

   always_ff @(posedge clk_50) begin
      if (reset || clr) begin
         sr_reg <= '0;
      end else if (ena) begin
         sr_reg <= next_sr;
      end
   end

endmodule

// File: rtl/serial_word_framer.sv
// Serial-to-parallel framer: hunts for a header byte, then emits PKT_WORDS bytes.
// Build option: define HDR_CNT_EN to add the saturating hdr_count output.
module serial_word_framer
   import framer_pkg::*;
#(
   parameter int                PKT_WORDS = 4,
   parameter logic [BYTE_W-1:0] HDR_A     = HDR_A_DEF,
   parameter logic [BYTE_W-1:0] HDR_B     = HDR_B_DEF
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              serial_data,
   input  logic              data_ena,
   input  logic              fifo_full,
   output logic              header_found,
   output logic              header_type,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              overflow
`ifdef HDR_CNT_EN
   ,
   output logic [7:0]        hdr_count
`endif
);

   localparam logic [7:0] LAST_WORD = 8'(PKT_WORDS - 1);

   framer_state_t     state_reg, state_next;
   logic [2:0]        bit_cnt_reg, bit_cnt_next;
   logic [7:0]        word_cnt_reg, word_cnt_next;
   logic [BYTE_W-1:0] byte_out_reg, byte_out_next;
   logic              byte_valid_reg, byte_valid_next;
   logic              overflow_reg, overflow_next;
   logic              header_type_reg, header_type_next;

   logic [BYTE_W-1:0] next_sr;
   logic              hdr_hit;
   logic              byte_done;
   logic              last_byte;

   // Header detection and packet end both restart the window so old bits never alias.
   serial_shift8 u_shift (
      .clk_50  (clk_50),
      .reset   (reset),
      .ena     (data_ena),
      .clr     (hdr_hit || last_byte),
      .din     (serial_data),
      .next_sr (next_sr)
   );

   assign hdr_hit   = data_ena && (state_reg == HUNT) && is_header(next_sr, HDR_A, HDR_B);
   assign byte_done = data_ena && (state_reg == COLLECT) && (bit_cnt_reg == 3'd7);
   assign last_byte = byte_done && (word_cnt_reg == LAST_WORD);

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_reg       <= HUNT;
         bit_cnt_reg     <= '0;
         word_cnt_reg    <= '0;
         byte_out_reg    <= '0;
         byte_valid_reg  <= 1'b0;
         overflow_reg    <= 1'b0;
         header_type_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         word_cnt_reg    <= word_cnt_next;
         byte_out_reg    <= byte_out_next;
         byte_valid_reg  <= byte_valid_next;
         overflow_reg    <= overflow_next;
         header_type_reg <= header_type_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         HUNT:    if (hdr_hit)   state_next = COLLECT;
         COLLECT: if (last_byte) state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   always_comb begin
      bit_cnt_next     = bit_cnt_reg;
      word_cnt_next    = word_cnt_reg;
      byte_out_next    = byte_out_reg;
      byte_valid_next  = 1'b0;
      overflow_next    = overflow_reg;
      header_type_next = header_type_reg;
      if (hdr_hit) begin
         header_type_next = (next_sr == HDR_B);
         bit_cnt_next     = '0;
         word_cnt_next    = '0;
      end else if (data_ena && (state_reg == COLLECT)) begin
         bit_cnt_next = bit_cnt_reg + 3'd1;
         if (byte_done) begin
            // A dropped byte still counts toward the packet so framing stays intact.
            word_cnt_next = word_cnt_reg + 8'd1;
            if (fifo_full) begin
               overflow_next = 1'b1;
            end else begin
               byte_out_next   = next_sr;
               byte_valid_next = 1'b1;
            end
         end
      end
   end

   assign header_found = (state_reg == COLLECT);
   assign header_type  = header_type_reg;
   assign byte_out     = byte_out_reg;
   assign byte_valid   = byte_valid_reg;
   assign overflow     = overflow_reg;

`ifdef HDR_CNT_EN
   logic [7:0] hdr_count_reg;

   always_ff @(posedge clk_50) begin
      if (reset) begin
         hdr_count_reg <= '0;
      end else if (hdr_hit && (hdr_count_reg != 8'hFF)) begin
         hdr_count_reg <= hdr_count_reg + 8'd1;
      end
   end

   assign hdr_count = hdr_count_reg;
`endif

endmodule

// File: tb/tb_serial_word_framer.sv
// Directed self-checking bench for serial_word_framer (PKT_WORDS=4).
// Byte strobes are logged on the falling edge and compared per scenario.
module tb_serial_word_framer;

   logic       clk_50 = 1'b0;
   logic       reset;
   logic       serial_data;
   logic       data_ena;
   logic       fifo_full;
   logic       header_found;
   logic       header_type;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       overflow;
`ifdef HDR_CNT_EN
   logic [7:0] hdr_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] sq[$];
   int         st[$];
   logic       hq[$];

   always #10 clk_50 = ~clk_50;

   serial_word_framer #(.PKT_WORDS(4)) dut (
      .clk_50       (clk_50),
      .reset        (reset),
      .serial_data  (serial_data),
      .data_ena     (data_ena),
      .fifo_full    (fifo_full),
      .header_found (header_found),
      .header_type  (header_type),
      .byte_out     (byte_out),
      .byte_valid   (byte_valid),
      .overflow     (overflow)
`ifdef HDR_CNT_EN
      ,
      .hdr_count    (hdr_count)
`endif
   );

   always @(negedge clk_50) begin
      cyc++;
      if (byte_valid === 1'b1) begin
         sq.push_back(byte_out);
         st.push_back(cyc);
         hq.push_back(header_found);
         $display("strobe cycle %0d byte %h header_found %b", cyc, byte_out, header_found);
      end
   end

   task automatic clear_log();
      @(posedge clk_50);
      #1;
      sq.delete();
      st.delete();
      hq.delete();
   endtask

   task automatic send_bit(input logic b, input int gap);
      @(negedge clk_50);
      serial_data = b;
      data_ena    = 1'b1;
      repeat (gap) begin
         @(negedge clk_50);
         data_ena    = 1'b0;
         serial_data = ~b;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_50);
         data_ena = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_50);
      reset     = 1'b1;
      data_ena  = 1'b0;
      fifo_full = 1'b0;
      @(negedge clk_50);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; data_ena = 1'b0; serial_data = 1'b0; fifo_full = 1'b0;
      repeat (3) @(posedge clk_50);
      #1;
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL reset_header_found: got %b expected 0", header_found); end
      checks++; if (header_type !== 1'b0) begin errors++; $display("FAIL reset_header_type: got %b expected 0", header_type); end
      checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`ifdef HDR_CNT_EN
      checks++; if (hdr_count !== 8'h00) begin errors++; $display("FAIL reset_hdr_count: got %h expected 00", hdr_count); end
`endif
      reset = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      clear_log();
      send_byte(8'hA5, 0);
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL basic_hf_early: got %b expected 0", header_found); end
      @(posedge clk_50); #1;
      checks++; if (header_found !== 1'b1) begin errors++; $display("FAIL basic_hf_rise: got %b expected 1", header_found); end
      checks++; if (header_type !== 1'b0) begin errors++; $display("FAIL basic_type: got %b expected 0", header_type); end
      for (int i = 0; i < 4; i++) send_byte(exp[i], 0);
      @(posedge clk_50); #1;
      checks++; if (byte_valid !== 1'b1 || byte_out !== 8'h44) begin errors++; $display("FAIL basic_last_strobe: got %b/%h expected 1/44", byte_valid, byte_out); end
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL basic_hf_fall: got %b expected 0", header_found); end
      idle(3);
      checks++; if (byte_out !== 8'h44) begin errors++; $display("FAIL basic_hold: got %h expected 44", byte_out); end
      checks++; if (sq.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", sq.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i >= sq.size() || sq[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, (i < sq.size()) ? sq[i] : 8'hxx, exp[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         checks++; if (i >= st.size() || st[i] - st[i-1] != 8) begin errors++; $display("FAIL basic_spacing%0d: got %0d expected 8", i, (i < st.size()) ? st[i] - st[i-1] : -1); end
      end
      $display("test_basic done");
   endtask

   task automatic test_unaligned();
      clear_log();
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      send_byte(8'hC3, 0);
      @(posedge clk_50); #1;
      checks++; if (header_found !== 1'b1) begin errors++; $display("FAIL unal_hf: got %b expected 1", header_found); end
      checks++; if (header_type !== 1'b1) begin errors++; $display("FAIL unal_type: got %b expected 1", header_type); end
      for (int i = 0; i < 4; i++) send_byte(8'hFF, 0);
      idle(3);
      checks++; if (sq.size() != 4) begin errors++; $display("FAIL unal_count: got %0d expected 4", sq.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i >= sq.size() || sq[i] !== 8'hFF) begin errors++; $display("FAIL unal_byte%0d: got %h expected ff", i, (i < sq.size()) ? sq[i] : 8'hxx); end
      end
      checks++; if (header_type !== 1'b1) begin errors++; $display("FAIL unal_type_hold: got %b expected 1", header_type); end
      $display("test_unaligned done");
   endtask

   task automatic test_gapped();
      logic [7:0] exp [4] = '{8'h5A, 8'h3C, 8'hE7, 8'h18};
      clear_log();
      send_byte(8'hA5, 2);
      checks++; if (header_found !== 1'b1) begin errors++; $display("FAIL gap_hf_in_gap: got %b expected 1", header_found); end
      checks++; if (header_type !== 1'b0) begin errors++; $display("FAIL gap_type: got %b expected 0", header_type); end
      for (int i = 0; i < 4; i++) send_byte(exp[i], 2);
      idle(2);
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL gap_hf_end: got %b expected 0", header_found); end
      checks++; if (sq.size() != 4) begin errors++; $display("FAIL gap_count: got %0d expected 4", sq.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i >= sq.size() || sq[i] !== exp[i]) begin errors++; $display("FAIL gap_byte%0d: got %h expected %h", i, (i < sq.size()) ? sq[i] : 8'hxx, exp[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         checks++; if (i >= st.size() || st[i] - st[i-1] != 24) begin errors++; $display("FAIL gap_spacing%0d: got %0d expected 24", i, (i < st.size()) ? st[i] - st[i-1] : -1); end
      end
      $display("test_gapped done");
   endtask

   task automatic test_fifo_full();
      clear_log();
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      @(posedge clk_50); #1;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ff_ovf_before: got %b expected 0", overflow); end
      fifo_full = 1'b1;
      send_byte(8'h20, 0);
      @(posedge clk_50); #1;
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL ff_no_strobe: got %b expected 0", byte_valid); end
      checks++; if (byte_out !== 8'h10) begin errors++; $display("FAIL ff_byte_held: got %h expected 10", byte_out); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ff_ovf_set: got %b expected 1", overflow); end
      fifo_full = 1'b0;
      send_byte(8'h30, 0);
      send_byte(8'h40, 0);
      @(posedge clk_50); #1;
      checks++; if (byte_valid !== 1'b1 || byte_out !== 8'h40) begin errors++; $display("FAIL ff_last_strobe: got %b/%h expected 1/40", byte_valid, byte_out); end
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL ff_hf_fall: got %b expected 0", header_found); end
      idle(3);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ff_ovf_sticky: got %b expected 1", overflow); end
      checks++; if (sq.size() != 3) begin errors++; $display("FAIL ff_count: got %0d expected 3", sq.size()); end
      checks++; if (sq.size() < 3 || sq[0] !== 8'h10 || sq[1] !== 8'h30 || sq[2] !== 8'h40) begin errors++; $display("FAIL ff_bytes: got %p expected 10 30 40", sq); end
      $display("test_fifo_full done");
   endtask

   task automatic test_reset_mid();
      clear_log();
      send_byte(8'hA5, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk_50);
      data_ena = 1'b0;
      reset    = 1'b1;
      @(posedge clk_50); #1;
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL rmid_hf: got %b expected 0", header_found); end
      checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL rmid_byte_out: got %h expected 00", byte_out); end
      checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rmid_byte_valid: got %b expected 0", byte_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b expected 0", overflow); end
      reset = 1'b0;
      checks++; if (sq.size() != 2) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 2", sq.size()); end
      clear_log();
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      idle(3);
      checks++; if (sq.size() != 0) begin errors++; $display("FAIL rmid_no_strobe: got %0d expected 0", sq.size()); end
      checks++; if (header_found !== 1'b0) begin errors++; $display("FAIL rmid_hunting: got %b expected 0", header_found); end
      send_byte(8'hA5, 0);
      @(posedge clk_50); #1;
      checks++; if (header_found !== 1'b1) begin errors++; $display("FAIL rmid_resync: got %b expected 1", header_found); end
      for (int i = 0; i < 4; i++) send_byte(8'h55 + 8'(i * 17), 0);
      idle(3);
      checks++; if (sq.size() != 4 || sq[0] !== 8'h55 || sq[3] !== 8'h88) begin errors++; $display("FAIL rmid_after: got %p expected 55 66 77 88", sq); end
      $display("test_reset_mid done");
   endtask

   task automatic test_back_to_back();
      logic [7:0] hdr [3] = '{8'hA5, 8'hC3, 8'hA5};
      do_reset();
      clear_log();
      for (int p = 0; p < 3; p++) begin
         send_byte(hdr[p], 0);
         for (int i = 0; i < 4; i++) send_byte(8'(p * 4 + i + 1), 0);
      end
      idle(3);
      checks++; if (sq.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", sq.size()); end
      for (int i = 0; i < 12; i++) begin
         checks++; if (i >= sq.size() || sq[i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < sq.size()) ? sq[i] : 8'hxx, 8'(i + 1)); end
      end
      checks++; if (st.size() < 5 || st[4] - st[3] != 16) begin errors++; $display("FAIL b2b_gap: got %0d expected 16", (st.size() >= 5) ? st[4] - st[3] : -1); end
      checks++; if (hq.size() < 4 || hq[3] !== 1'b0 || hq[2] !== 1'b1) begin errors++; $display("FAIL b2b_hf_at_strobe: got %p expected 1 at byte 3, 0 at byte 4", hq); end
      checks++; if (header_type !== 1'b0) begin errors++; $display("FAIL b2b_type: got %b expected 0", header_type); end
`ifdef HDR_CNT_EN
      checks++; if (hdr_count !== 8'd3) begin errors++; $display("FAIL b2b_hdr_count: got %0d expected 3", hdr_count); end
`endif
      $display("test_back_to_back done");
   endtask

`ifdef HDR_CNT_EN
   task automatic test_hdr_saturate();
      for (int p = 3; p < 255; p++) begin
         send_byte(8'hC3, 0);
         for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
      end
      idle(2);
      checks++; if (hdr_count !== 8'hFF) begin errors++; $display("FAIL sat_255: got %h expected ff", hdr_count); end
      for (int p = 255; p < 260; p++) begin
         send_byte(8'hA5, 0);
         for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
      end
      idle(2);
      checks++; if (hdr_count !== 8'hFF) begin errors++; $display("FAIL sat_260: got %h expected ff", hdr_count); end
      $display("test_hdr_saturate done");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_unaligned();
      test_gapped();
      test_fifo_full();
      test_reset_mid();
      test_back_to_back();
`ifdef HDR_CNT_EN
      test_hdr_saturate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_word_framer.md
Name: serial_word_framer

Overview:
- Serial-to-parallel front end of the hw6 receive path.
- Shifts in a 1-bit serial stream and hunts for header byte 0xA5 or 0xC3.
- After a header, assembles the next PKT_WORDS bytes and presents each with a one-cycle valid strobe.
- Drives the header_found level consumed by the FIFO write-control stage, and the byte bus feeding the FIFO.

Parameters:
- PKT_WORDS, 4: data bytes collected after each header; legal range 1..255.
- HDR_A, 8'hA5: first accepted header value.
- HDR_B, 8'hC3: second accepted header value.

Ports:
- clk_50  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_data  input  1  serial bit, MSB first; sampled only when data_ena=1.
- data_ena  input  1  bit-valid qualifier; one bit consumed per clock while high.
- fifo_full  input  1  downstream FIFO full flag.
- header_found  output  1  high while in COLLECT state.
- header_type  output  1  0 = HDR_A matched, 1 = HDR_B matched; held until the next header.
- byte_out  output  8  assembled data byte.
- byte_valid  output  1  one-cycle strobe; byte_out valid this cycle.
- overflow  output  1  sticky; a byte was dropped because fifo_full was set.
- hdr_count  output  8  headers detected (present only with HDR_CNT_EN).

Behaviour:
- Reset (sync, active-high, checked on clk_50 edge):
  - state=HUNT; sr=8'h00; bit_cnt=0; word_cnt=0.
  - All outputs 0, including hdr_count.
  - Reset wins over every other event in the same cycle; an aborted packet is discarded with no strobe.
- Shift:
  - next_sr = {sr[6:0], serial_data}.
  - sr <= next_sr only on cycles with data_ena=1.
  - data_ena=0 freezes sr, bit_cnt, word_cnt and state; there is no timeout.
- HUNT state:
  - On a data_ena cycle, if next_sr==HDR_A or next_sr==HDR_B:
    - state<=COLLECT; header_found<=1; header_type<=(next_sr==HDR_B).
    - sr<=0; bit_cnt<=0; word_cnt<=0.
  - Otherwise keep shifting. Matching is bit-by-bit (sliding window), not byte-aligned.
- COLLECT state:
  - Each data_ena cycle increments bit_cnt (3-bit, wraps 7->0).
  - On the data_ena cycle where bit_cnt==7: byte_out<=next_sr; byte_valid<=1 for exactly one cycle; word_cnt++.
  - Latency: the byte appears the cycle after its 8th bit is sampled.
  - byte_out holds its value until the next byte.
- Packet end:
  - On the edge that registers byte PKT_WORDS: state<=HUNT; header_found<=0; sr<=0.
  - So header_found falls on the same edge byte_valid rises for the last byte.
  - Header values have MSB=1 and sr restarts at 0, so a new header needs 8 fresh bits; bits of the previous packet can never alias.
- Headers inside COLLECT are treated as data; no re-sync.
- fifo_full:
  - If a byte completes while fifo_full=1: byte_valid stays 0, byte_out is not updated, overflow<=1, and word_cnt still increments (packet framing is preserved).
  - overflow clears only on reset.
- Widths: word_cnt is 8-bit; terminal compare is word_cnt==PKT_WORDS-1 at byte completion.

Optional Feature:
- Macro: HDR_CNT_EN.
- Defined: port hdr_count exists. It is an 8-bit counter incremented on each header detection, saturating at 8'hFF, cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package framer_pkg holds:
  - typedef enum logic {HUNT, COLLECT} framer_state_t;
  - localparams HDR_A_DEF=8'hA5 and HDR_B_DEF=8'hC3;
  - BYTE_W=8.
- One sub-module: serial_shift8 (8-bit enabled shift register with synchronous clear, exposing next_sr).
- Top level holds the FSM, counters and output registers.

Test Plan:
- Reset mid-packet: reset high for 1 cycle after 2 of 4 bytes -> all outputs 0 next cycle; no further byte_valid until a new 0xA5 is sent.
- Stream 0xA5,0x11,0x22,0x33,0x44 with data_ena=1 continuous -> header_found rises 1 cycle after the 8th header bit; header_type=0; byte_valid pulses carry 0x11,0x22,0x33,0x44, 8 cycles apart; header_found falls with the 0x44 strobe.
- Unaligned header: bits 101 then 0xC3 then 4 bytes 0xFF -> header_type=1; four 0xFF strobes.
- data_ena gapped (1 on, 2 off) over 0xA5,0x5A,... -> identical byte values; strobe spacing 24 cycles; no state change during gaps.
- fifo_full=1 during the 2nd data byte -> that byte has no strobe; overflow=1 and stays set; 3rd and 4th bytes still strobe; header_found falls after the 4th.
- Back-to-back packets plus HDR_CNT_EN: three packets (A5,C3,A5) -> hdr_count=3; 260 headers -> hdr_count=8'hFF.
